// File: rtl/axi_drain_pkg.sv
// Shared types and defaults for the AXI clock-converter drain controller.
package axi_drain_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } drain_state_e;

    localparam int DEFAULT_MAX_OUTSTANDING = 16;

endpackage

// File: rtl/axi_outstanding_counter.sv
// Up/down transaction counter. Unsigned mode saturates at 0 and flags underflow;
// signed mode wraps through zero so a lead of the decrement side can be tracked.
module axi_outstanding_counter #(
    parameter int WIDTH       = 5,
    parameter int MAX_COUNT   = 16,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_underflow
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_count;
    logic             w_floor;

    generate
        if (SIGNED_MODE) begin : g_signed
            assign w_floor = 1'b0;
        end else begin : g_unsigned
            assign w_floor = (r_count == '0);
        end
    endgenerate

    // A simultaneous increment and decrement cancels and is never an underflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != MAX_VAL)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && !w_floor) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_underflow = i_dec & ~i_inc & w_floor;
    assign o_count     = r_count;

endmodule

// File: rtl/axi_cdc_drain_ctrl.sv
// Outstanding-transaction gate and drain sequencer in front of the clock converter.
// Optional drain watchdog and drain_err_o port are enabled with DRAIN_TIMEOUT_EN.
module axi_cdc_drain_ctrl
    import axi_drain_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
`ifdef DRAIN_TIMEOUT_EN
    parameter int DRAIN_TIMEOUT   = 1024,
`endif
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 axi_aclk,
    input  logic                 axi_areset,
    input  logic                 drain_req_i,
    output logic                 drain_ack_o,
    input  logic                 s_awvalid_i,
    output logic                 s_awready_o,
    output logic                 m_awvalid_o,
    input  logic                 m_awready_i,
    input  logic                 s_arvalid_i,
    output logic                 s_arready_o,
    output logic                 m_arvalid_o,
    input  logic                 m_arready_i,
    input  logic                 w_beat_last_i,
    input  logic                 b_done_i,
    input  logic                 r_done_i,
    output logic [CNT_WIDTH-1:0] wr_cnt_o,
    output logic [CNT_WIDTH-1:0] rd_cnt_o,
    output logic                 proto_err_o
`ifdef DRAIN_TIMEOUT_EN
    ,
    output logic                 drain_err_o
`endif
);

    drain_state_e r_state, w_state_next;

    // Channel index 0 is the write address channel, 1 the read address channel.
    logic [1:0]           w_s_valid, w_m_ready, w_m_valid, w_s_ready;
    logic [1:0]           w_open, w_hs, w_dec, w_uflow, w_ch_quiet;
    logic [CNT_WIDTH-1:0] w_cnt [2];
    logic [CNT_WIDTH:0]   w_wlast_cnt;
    logic                 w_wlast_uflow;
    logic                 w_quiet, w_timeout;
    logic                 r_proto_err;

    assign w_s_valid = {s_arvalid_i, s_awvalid_i};
    assign w_m_ready = {m_arready_i, m_awready_i};
    assign w_dec     = {r_done_i, b_done_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic r_pending;

            // An address already shown downstream stays open until it is accepted.
            assign w_open[gi]    = r_pending |
                                   ((r_state == RUN) && (w_cnt[gi] < CNT_WIDTH'(MAX_OUTSTANDING)));
            assign w_m_valid[gi] = w_s_valid[gi] & w_open[gi];
            assign w_s_ready[gi] = w_m_ready[gi] & w_open[gi];
            assign w_hs[gi]      = w_s_valid[gi] & w_m_ready[gi] & w_open[gi];
            assign w_ch_quiet[gi] = ~r_pending & (w_cnt[gi] == '0);

            always_ff @(posedge axi_aclk) begin
                if (axi_areset) begin
                    r_pending <= 1'b0;
                end else if (w_hs[gi]) begin
                    r_pending <= 1'b0;
                end else if (w_m_valid[gi] && !w_m_ready[gi]) begin
                    r_pending <= 1'b1;
                end
            end

            axi_outstanding_counter #(
                .WIDTH       (CNT_WIDTH),
                .MAX_COUNT   (MAX_OUTSTANDING),
                .SIGNED_MODE (1'b0)
            ) u_cnt (
                .clk         (axi_aclk),
                .srst        (axi_areset),
                .i_inc       (w_hs[gi]),
                .i_dec       (w_dec[gi]),
                .o_count     (w_cnt[gi]),
                .o_underflow (w_uflow[gi])
            );
        end
    endgenerate

    // W may lead AW, so the wlast balance is signed and may dip below zero.
    axi_outstanding_counter #(
        .WIDTH       (CNT_WIDTH + 1),
        .MAX_COUNT   (MAX_OUTSTANDING),
        .SIGNED_MODE (1'b1)
    ) u_wlast_cnt (
        .clk         (axi_aclk),
        .srst        (axi_areset),
        .i_inc       (w_hs[0]),
        .i_dec       (w_beat_last_i),
        .o_count     (w_wlast_cnt),
        .o_underflow (w_wlast_uflow)
    );

    assign w_quiet = (&w_ch_quiet) && (w_wlast_cnt == '0);

`ifdef DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [TO_W-1:0] r_timeout;
    logic            r_drain_err;

    // Held at zero outside DRAIN, so every drain starts a fresh budget.
    assign w_timeout = (r_timeout == TO_W'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge axi_aclk) begin
        if (axi_areset || (r_state != DRAIN)) begin
            r_timeout <= '0;
        end else begin
            r_timeout <= r_timeout + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_drain_err <= 1'b0;
        end else if ((r_state == RUN) && drain_req_i) begin
            r_drain_err <= 1'b0;
        end else if ((r_state == DRAIN) && drain_req_i && !w_quiet && w_timeout) begin
            r_drain_err <= 1'b1;
        end
    end

    assign drain_err_o = r_drain_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state     <= RUN;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_proto_err <= r_proto_err | (|w_uflow) | w_wlast_uflow;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (drain_req_i) w_state_next = DRAIN;
            DRAIN: begin
                if (!drain_req_i)             w_state_next = RUN;
                else if (w_quiet || w_timeout) w_state_next = IDLE;
            end
            IDLE:    if (!drain_req_i) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign drain_ack_o = (r_state == IDLE);
    assign m_awvalid_o = w_m_valid[0];
    assign s_awready_o = w_s_ready[0];
    assign m_arvalid_o = w_m_valid[1];
    assign s_arready_o = w_s_ready[1];
    assign wr_cnt_o    = w_cnt[0];
    assign rd_cnt_o    = w_cnt[1];
    assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_axi_cdc_drain_ctrl.sv
// Bench for axi_cdc_drain_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_axi_cdc_drain_ctrl;

    localparam int MAXO = 16;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          srst;
    logic          drain_req_i, drain_ack_o;
    logic          s_awvalid_i, s_awready_o, m_awvalid_o, m_awready_i;
    logic          s_arvalid_i, s_arready_o, m_arvalid_o, m_arready_i;
    logic          w_beat_last_i, b_done_i, r_done_i;
    logic [CW-1:0] wr_cnt_o, rd_cnt_o;
    logic          proto_err_o;

    always #5 clk = ~clk;

    axi_cdc_drain_ctrl dut (
        .axi_aclk      (clk),
        .axi_areset    (srst),
        .drain_req_i   (drain_req_i),
        .drain_ack_o   (drain_ack_o),
        .s_awvalid_i   (s_awvalid_i),
        .s_awready_o   (s_awready_o),
        .m_awvalid_o   (m_awvalid_o),
        .m_awready_i   (m_awready_i),
        .s_arvalid_i   (s_arvalid_i),
        .s_arready_o   (s_arready_o),
        .m_arvalid_o   (m_arvalid_o),
        .m_arready_i   (m_arready_i),
        .w_beat_last_i (w_beat_last_i),
        .b_done_i      (b_done_i),
        .r_done_i      (r_done_i),
        .wr_cnt_o      (wr_cnt_o),
        .rd_cnt_o      (rd_cnt_o),
        .proto_err_o   (proto_err_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Transaction-level model: plain integer tallies and a three-way mode.
    typedef enum int {M_RUN, M_DRAIN, M_IDLE} mode_t;
    mode_t m_mode;
    int    m_wr, m_rd, m_wl;
    bit    m_pend_aw, m_pend_ar, m_perr;

    function automatic bit aw_gate();
        return m_pend_aw || (m_mode == M_RUN && m_wr < MAXO);
    endfunction

    function automatic bit ar_gate();
        return m_pend_ar || (m_mode == M_RUN && m_rd < MAXO);
    endfunction

    always @(posedge clk) begin : model
        bit ga, gr, aw_hs, ar_hs, quiet;
        int nwr, nrd;
        if (srst) begin
            m_mode <= M_RUN; m_wr <= 0; m_rd <= 0; m_wl <= 0;
            m_pend_aw <= 1'b0; m_pend_ar <= 1'b0; m_perr <= 1'b0;
        end else begin
            ga    = aw_gate();
            gr    = ar_gate();
            aw_hs = s_awvalid_i && m_awready_i && ga;
            ar_hs = s_arvalid_i && m_arready_i && gr;
            quiet = (m_wr == 0) && (m_rd == 0) && (m_wl == 0) && !m_pend_aw && !m_pend_ar;
            case (m_mode)
                M_RUN:   if (drain_req_i) m_mode <= M_DRAIN;
                M_DRAIN: if (!drain_req_i) m_mode <= M_RUN; else if (quiet) m_mode <= M_IDLE;
                default: if (!drain_req_i) m_mode <= M_RUN;
            endcase
            nwr = m_wr + int'(aw_hs) - int'(b_done_i);
            nrd = m_rd + int'(ar_hs) - int'(r_done_i);
            if (nwr < 0 || nrd < 0) m_perr <= 1'b1;
            m_wr <= (nwr < 0) ? 0 : nwr;
            m_rd <= (nrd < 0) ? 0 : nrd;
            m_wl <= m_wl + int'(aw_hs) - int'(w_beat_last_i);
            m_pend_aw <= aw_hs ? 1'b0 : (m_pend_aw || (s_awvalid_i && ga && !m_awready_i));
            m_pend_ar <= ar_hs ? 1'b0 : (m_pend_ar || (s_arvalid_i && gr && !m_arready_i));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_awvalid", m_awvalid_o, s_awvalid_i && aw_gate());
            check("s_awready", s_awready_o, m_awready_i && aw_gate());
            check("m_arvalid", m_arvalid_o, s_arvalid_i && ar_gate());
            check("s_arready", s_arready_o, m_arready_i && ar_gate());
            check("wr_cnt", int'(wr_cnt_o), m_wr);
            check("rd_cnt", int'(rd_cnt_o), m_rd);
            check("drain_ack", drain_ack_o, m_mode == M_IDLE);
            check("proto_err", proto_err_o, m_perr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        drain_req_i = 0; s_awvalid_i = 0; m_awready_i = 0; s_arvalid_i = 0;
        m_arready_i = 0; w_beat_last_i = 0; b_done_i = 0; r_done_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        srst = 1;
        repeat (3) step();
        srst = 0;
    endtask

    initial begin
        srst = 1;
        do_reset();
        chk_en = 1'b1;
        check("rst_wr_cnt", int'(wr_cnt_o), 0);
        check("rst_rd_cnt", int'(rd_cnt_o), 0);
        check("rst_ack", drain_ack_o, 0);
        check("rst_proto_err", proto_err_o, 0);

        // Four writes in, four responses out.
        for (int i = 0; i < 4; i++) begin
            s_awvalid_i = 1; m_awready_i = 1; w_beat_last_i = 1;
            step();
            clear_inputs();
            check("A_wr_up", int'(wr_cnt_o), i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            b_done_i = 1;
            step();
            clear_inputs();
            check("A_wr_down", int'(wr_cnt_o), 3 - i);
        end
        check("A_proto_err", proto_err_o, 0);

        // Read limit: 16 accepted, 17th blocked until a read completes.
        for (int i = 0; i < MAXO; i++) begin
            s_arvalid_i = 1; m_arready_i = 1;
            step();
        end
        check("B_rd_full", int'(rd_cnt_o), 16);
        check("B_arready_blk", s_arready_o, 0);
        check("B_arvalid_blk", m_arvalid_o, 0);
        step();
        check("B_rd_hold", int'(rd_cnt_o), 16);
        r_done_i = 1;
        step();
        r_done_i = 0;
        check("B_rd_after_r", int'(rd_cnt_o), 15);
        check("B_arready_open", s_arready_o, 1);
        step();
        check("B_rd_refill", int'(rd_cnt_o), 16);
        clear_inputs();
        for (int i = 0; i < MAXO; i++) begin
            r_done_i = 1;
            step();
        end
        clear_inputs();
        check("B_rd_empty", int'(rd_cnt_o), 0);

        // Drain with three writes outstanding.
        for (int i = 0; i < 3; i++) begin
            s_awvalid_i = 1; m_awready_i = 1; w_beat_last_i = 1;
            step();
        end
        clear_inputs();
        drain_req_i = 1;
        step();
        s_awvalid_i = 1; m_awready_i = 1;
        #1;
        check("C_awready_blk", s_awready_o, 0);
        check("C_awvalid_blk", m_awvalid_o, 0);
        s_awvalid_i = 0; m_awready_i = 0;
        for (int i = 0; i < 3; i++) begin
            b_done_i = 1;
            step();
        end
        b_done_i = 0;
        check("C_wr_zero", int'(wr_cnt_o), 0);
        check("C_ack_early", drain_ack_o, 0);
        step();
        check("C_ack", drain_ack_o, 1);
        drain_req_i = 0;
        step();
        check("C_ack_drop", drain_ack_o, 0);
        s_awvalid_i = 1; m_awready_i = 1; w_beat_last_i = 1;
        #1;
        check("C_resume", s_awready_o, 1);
        step();
        clear_inputs();
        b_done_i = 1;
        step();
        clear_inputs();

        // Address pending across the drain request must not be withdrawn.
        s_awvalid_i = 1; m_awready_i = 0;
        step();
        drain_req_i = 1;
        step();
        check("D_awvalid_held", m_awvalid_o, 1);
        step();
        check("D_awvalid_held2", m_awvalid_o, 1);
        check("D_no_ack", drain_ack_o, 0);
        m_awready_i = 1;
        step();
        check("D_wr_one", int'(wr_cnt_o), 1);
        s_awvalid_i = 0; m_awready_i = 0; w_beat_last_i = 1; b_done_i = 1;
        step();
        w_beat_last_i = 0; b_done_i = 0;
        check("D_wr_zero", int'(wr_cnt_o), 0);
        step();
        check("D_ack", drain_ack_o, 1);
        drain_req_i = 0;
        step();

        // Response with nothing outstanding.
        b_done_i = 1;
        step();
        b_done_i = 0;
        check("E_wr_sat", int'(wr_cnt_o), 0);
        check("E_proto_err", proto_err_o, 1);
        repeat (3) step();
        check("E_proto_sticky", proto_err_o, 1);

        // Randomized traffic with drain requests toggling.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) drain_req_i = ~drain_req_i;
            s_awvalid_i   = m_pend_aw || ($urandom_range(0, 3) == 0);
            s_arvalid_i   = m_pend_ar || ($urandom_range(0, 3) == 0);
            m_awready_i   = ($urandom_range(0, 2) != 0);
            m_arready_i   = ($urandom_range(0, 2) != 0);
            w_beat_last_i = (m_wl > -2) && ($urandom_range(0, 3) == 0);
            b_done_i      = (m_wr > 0 && m_wl < m_wr && $urandom_range(0, 2) == 0) ||
                            (m_wr == 0 && $urandom_range(0, 499) == 0);
            r_done_i      = (m_rd > 0 && $urandom_range(0, 2) == 0) ||
                            (m_rd == 0 && $urandom_range(0, 499) == 0);
            step();
        end

        do_reset();
        check("F_proto_cleared", proto_err_o, 0);
        check("F_wr_cleared", int'(wr_cnt_o), 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_cdc_drain_ctrl.md
Name: axi_cdc_drain_ctrl

Overview:
- Sequencing controller placed in front of the slave port of the AXI clock-converter wrapper, in the upstream (slave-side) clock domain.
- Counts outstanding write and read transactions and gates new AW/AR address handshakes.
- On request, drains the converter to a quiescent state so software or the reset controller can safely reset or re-clock the converter.
- Observes W/B/R handshakes; passes all payload signals straight through and does not touch them.

Parameters:
- MAX_OUTSTANDING, 16, maximum in-flight transactions per direction; new addresses are blocked at this limit.
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), counter width (derived; do not override).
- DRAIN_TIMEOUT, 1024, cycle budget for a drain; used only with DRAIN_TIMEOUT_EN.

Ports:
- axi_aclk  in  1  single clock.
- axi_areset  in  1  reset; synchronous, active-high.
- drain_req_i  in  1  level request to quiesce.
- drain_ack_o  out  1  converter idle, no transactions in flight.
- s_awvalid_i  in  1 / s_awready_o  out  1  upstream AW handshake.
- m_awvalid_o  out  1 / m_awready_i  in  1  converter AW handshake.
- s_arvalid_i  in  1 / s_arready_o  out  1  upstream AR handshake.
- m_arvalid_o  out  1 / m_arready_i  in  1  converter AR handshake.
- w_beat_last_i  in  1  wvalid&wready&wlast at the converter slave port.
- b_done_i  in  1  bvalid&bready.
- r_done_i  in  1  rvalid&rready&rlast.
- wr_cnt_o  out  CNT_WIDTH  outstanding writes (AW accepted, B not yet returned).
- rd_cnt_o  out  CNT_WIDTH  outstanding reads.
- proto_err_o  out  1  sticky counter-underflow flag.

Behaviour:
- Reset values: state RUN; all counters 0; drain_ack_o=0; proto_err_o=0; pending flags 0.
- Gating is combinational; there is zero latency on the passthrough path.
  - m_awvalid_o = s_awvalid_i & aw_open.
  - s_awready_o = m_awready_i & aw_open.
  - aw_open = aw_pending | (state==RUN & wr_cnt_o<MAX_OUTSTANDING).
  - The AR channel is gated identically.
- AXI valid stability: aw_pending is set when m_awvalid_o=1 and m_awready_i=0, and cleared on handshake. While set, the channel stays open regardless of state or count. A presented address is never withdrawn.
- wr_cnt:
  - +1 on AW handshake.
  - -1 on b_done_i.
  - Simultaneous +1/-1 leaves the count unchanged.
- wlast counter (internal): +1 on AW handshake, -1 on w_beat_last_i. It may go transiently negative because W may lead AW, so it is a signed CNT_WIDTH+1 value.
- rd_cnt: +1 on AR handshake, -1 on r_done_i.
- Underflow: a decrement at 0 (wr/rd) saturates at 0 and sets proto_err_o. proto_err_o clears only on reset.
- State machine:
  - RUN: traffic passes. Go to DRAIN when drain_req_i=1.
  - DRAIN: new addresses blocked (pending ones complete). Go to IDLE when wr_cnt=0, rd_cnt=0, wlast counter=0, and no pending flags.
  - IDLE: drain_ack_o=1, traffic blocked. Go to RUN when drain_req_i=0; drain_ack_o drops in the same cycle as the transition.
- drain_req_i deasserted while in DRAIN: return to RUN next cycle; no ack is issued.
- Reset asserted mid-drain: everything returns to reset values. Upstream must be reset alongside.

Optional Feature:
- DRAIN_TIMEOUT_EN defined:
  - Adds a timeout counter, cleared on entry to DRAIN.
  - When it reaches DRAIN_TIMEOUT, the FSM forces IDLE and asserts output drain_err_o. drain_err_o stays set until the next RUN->DRAIN transition.
- Undefined: no counter and no drain_err_o port; DRAIN waits indefinitely.

Decomposition:
- Package axi_drain_pkg holds:
  - enum drain_state_e {RUN, DRAIN, IDLE}.
  - Default constant for MAX_OUTSTANDING.
- Sub-module axi_outstanding_counter: parameterised up/down saturating counter with underflow flag, instantiated three times (wr, wlast, rd; wlast in signed mode).

Test Plan:
- Reset, 4 AW handshakes, then 4 b_done_i → wr_cnt_o goes 1,2,3,4 then back to 0; proto_err_o=0.
- Issue 16 ARs with no R → 17th AR sees s_arready_o=0 until one r_done_i, then accepts next cycle.
- 3 writes outstanding, assert drain_req_i → new AW blocked; drain_ack_o=1 one cycle after the last b_done_i; release request → RUN, traffic resumes.
- s_awvalid_i held with m_awready_i=0, drain_req_i rises → m_awvalid_o stays 1 until handshake, wr_cnt_o=1, then drains normally.
- b_done_i pulse at wr_cnt_o=0 → wr_cnt_o stays 0, proto_err_o=1 (sticky).
- DRAIN_TIMEOUT_EN with DRAIN_TIMEOUT=8, one read never completing → IDLE after 8 cycles, drain_err_o=1, drain_ack_o=1.
